// File: rtl/alu_issue_pkg.sv
// Shared types and decode helpers for the ALU issue stage: instruction/register
// types, RV32I ALU match masks, instruction classification and immediate builders.
package alu_issue_pkg;

    typedef logic [31:0] instruction_t;
    typedef logic [31:0] register_t;

    // Field masks: opcode only, opcode+funct3, opcode+funct3+funct7.
    localparam instruction_t M_OPC       = 32'h0000_007F;
    localparam instruction_t M_OPC_F3    = 32'h0000_707F;
    localparam instruction_t M_OPC_F3_F7 = 32'hFE00_707F;

    // Register-register ALU ops (match under M_OPC_F3_F7).
    localparam instruction_t M_ADD  = 32'h0000_0033;
    localparam instruction_t M_SUB  = 32'h4000_0033;
    localparam instruction_t M_SLL  = 32'h0000_1033;
    localparam instruction_t M_SLT  = 32'h0000_2033;
    localparam instruction_t M_SLTU = 32'h0000_3033;
    localparam instruction_t M_XOR  = 32'h0000_4033;
    localparam instruction_t M_SRL  = 32'h0000_5033;
    localparam instruction_t M_SRA  = 32'h4000_5033;
    localparam instruction_t M_OR   = 32'h0000_6033;
    localparam instruction_t M_AND  = 32'h0000_7033;

    // Register-immediate ALU ops (match under M_OPC_F3).
    localparam instruction_t M_ADDI  = 32'h0000_0013;
    localparam instruction_t M_SLTI  = 32'h0000_2013;
    localparam instruction_t M_SLTIU = 32'h0000_3013;
    localparam instruction_t M_XORI  = 32'h0000_4013;
    localparam instruction_t M_ORI   = 32'h0000_6013;
    localparam instruction_t M_ANDI  = 32'h0000_7013;

    // Immediate shifts (match under M_OPC_F3_F7; funct7 must be exact).
    localparam instruction_t M_SLLI = 32'h0000_1013;
    localparam instruction_t M_SRLI = 32'h0000_5013;
    localparam instruction_t M_SRAI = 32'h4000_5013;

    // Upper-immediate ops (match under M_OPC).
    localparam instruction_t M_LUI   = 32'h0000_0037;
    localparam instruction_t M_AUIPC = 32'h0000_0017;

    // Operand-source class of an instruction; CLS_NONE means not an ALU op.
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_REG,
        CLS_IMM,
        CLS_SHAMT,
        CLS_LUI,
        CLS_AUIPC
    } op_class_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } issue_state_t;

    function automatic op_class_t decode_instr(input instruction_t i);
        op_class_t    c;
        instruction_t m1;
        instruction_t m3;
        instruction_t m7;
        m1 = i & M_OPC;
        m3 = i & M_OPC_F3;
        m7 = i & M_OPC_F3_F7;
        c  = CLS_NONE;
        if (m1 == M_LUI) begin
            c = CLS_LUI;
        end else if (m1 == M_AUIPC) begin
            c = CLS_AUIPC;
        end else if (m7 inside {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU,
                                M_XOR, M_SRL, M_SRA, M_OR, M_AND}) begin
            c = CLS_REG;
        end else if (m3 inside {M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI}) begin
            c = CLS_IMM;
        end else if (m7 inside {M_SLLI, M_SRLI, M_SRAI}) begin
            c = CLS_SHAMT;
        end
        return c;
    endfunction

    function automatic logic is_alu_op(input instruction_t i);
        return decode_instr(i) != CLS_NONE;
    endfunction

    function automatic register_t imm_i(input instruction_t i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic register_t imm_u(input instruction_t i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic register_t shamt_i(input instruction_t i);
        return {27'b0, i[24:20]};
    endfunction

endpackage

// File: rtl/alu_issue_imm_gen.sv
// Combinational operand builder: classifies the incoming instruction and selects
// op1/op2 from register read data, the I/U immediates, the shift amount or the PC.
module alu_imm_gen
    import alu_issue_pkg::*;
(
    input  instruction_t instr,
    input  register_t    pc,
    input  register_t    rs1_data,
    input  register_t    rs2_data,
    output register_t    op1,
    output register_t    op2,
    output logic         is_alu
);

    op_class_t cls;

    assign cls    = decode_instr(instr);
    assign is_alu = (cls != CLS_NONE);

    // Operand mux keyed on instruction class; non-ALU instructions yield zeros.
    always_comb begin
        op1 = '0;
        op2 = '0;
        case (cls)
            CLS_REG: begin
                op1 = rs1_data;
                op2 = rs2_data;
            end
            CLS_IMM: begin
                op1 = rs1_data;
                op2 = imm_i(instr);
            end
            CLS_SHAMT: begin
                op1 = rs1_data;
                op2 = shamt_i(instr);
            end
            CLS_LUI: begin
                op1 = imm_u(instr);
                op2 = '0;
            end
            CLS_AUIPC: begin
                op1 = imm_u(instr);
                op2 = pc;
            end
            default: begin
                op1 = '0;
                op2 = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one instruction, builds operands from the regfile
// read ports, pulses the ALU enable for one cycle, then writes the registered
// ALU result back to rd. Only one op is ever in flight.
//
//  state | meaning
//  IDLE  | ready for a new instruction; illegal decode stays here
//  ISSUE | alu_enable high with latched instr/op1/op2
//  WAIT  | ALU result/exec flag valid; drive writeback or illegal
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter bit trace = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  instruction_t in_instr,
    input  register_t    in_pc,
    output logic [4:0]   rs1_addr,
    output logic [4:0]   rs2_addr,
    input  register_t    rs1_data,
    input  register_t    rs2_data,
    output logic         alu_enable,
    output instruction_t alu_instr,
    output register_t    alu_op1,
    output register_t    alu_op2,
    input  logic         alu_instr_exec,
    input  register_t    alu_result,
    output logic         wb_en,
    output logic [4:0]   wb_addr,
    output register_t    wb_data,
    output logic         illegal,
    output logic         busy
);

    issue_state_t state;
    register_t    gen_op1;
    register_t    gen_op2;
    logic         gen_is_alu;
    logic         illegal_dec;
    logic         in_wait;
    logic [4:0]   rd;

    // The regfile is read combinationally in the accept cycle.
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    alu_imm_gen u_imm_gen (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .op1      (gen_op1),
        .op2      (gen_op2),
        .is_alu   (gen_is_alu)
    );

    // Issue FSM with registered handshake, ALU drive and decode-illegal flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            alu_enable  <= 1'b0;
            alu_instr   <= '0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            illegal_dec <= 1'b0;
        end else begin
            alu_enable  <= 1'b0;
            illegal_dec <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (gen_is_alu) begin
                            alu_instr  <= in_instr;
                            alu_op1    <= gen_op1;
                            alu_op2    <= gen_op2;
                            alu_enable <= 1'b1;
                            in_ready   <= 1'b0;
                            state      <= ISSUE;
                        end else begin
                            illegal_dec <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Writeback is driven straight from the registered ALU outputs during WAIT so
    // the regfile is updated on the same edge that re-opens the input; the next
    // accepted instruction therefore always reads the new value.
    assign in_wait = (state == WAIT);
    assign rd      = alu_instr[11:7];
    assign wb_en   = in_wait && alu_instr_exec && (rd != 5'd0);
    assign wb_addr = in_wait ? rd : 5'd0;
    assign wb_data = in_wait ? alu_result : '0;
    assign illegal = illegal_dec || (in_wait && !alu_instr_exec);
    assign busy    = (state != IDLE);

`ifndef SYNTHESIS
    // Optional simulation trace of accepted and retired instructions.
    always @(posedge clk) begin
        if (trace && !rst) begin
            if (state == IDLE && in_valid && in_ready) begin
                $display("alu_issue: accept pc=%h instr=%h alu=%0b", in_pc, in_instr, gen_is_alu);
            end
            if (state == WAIT) begin
                $display("alu_issue: retire instr=%h exec=%0b rd=%0d result=%h",
                         alu_instr, alu_instr_exec, rd, alu_result);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural ALU and 32x32 regfile.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        alu_enable;
    logic [31:0] alu_instr, alu_op1, alu_op2;
    logic        alu_exec = 1'b0;
    logic [31:0] alu_res = 32'd0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { logic [31:0] op1; logic [31:0] op2; int cyc; } op_exp_t;
    typedef struct { bit ill; logic [4:0] addr; logic [31:0] data; int cyc; } ev_exp_t;

    op_exp_t     op_q[$];
    ev_exp_t     ev_q[$];
    bit          fail_q[$];
    logic [31:0] rf [32];
    logic [31:0] shadow [32];

    alu_issue #(.trace(1'b0)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .alu_enable     (alu_enable),
        .alu_instr      (alu_instr),
        .alu_op1        (alu_op1),
        .alu_op2        (alu_op2),
        .alu_instr_exec (alu_exec),
        .alu_result     (alu_res),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .illegal        (illegal),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural regfile, x0 hardwired to zero.
    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];
    always @(posedge clk) if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

    // Behavioural ALU: result and exec flag registered one cycle after enable.
    function automatic logic [31:0] alu_compute(input logic [31:0] ins, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] r;
        opc = ins[6:0];
        f3  = ins[14:12];
        alt = ins[30] && (opc == 7'h33 || f3 == 3'd5);
        if (opc == 7'h37 || opc == 7'h17) return a + b;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic bit take_fail();
        if (fail_q.size() == 0) return 1'b0;
        return fail_q.pop_front();
    endfunction

    always @(posedge clk) begin
        if (alu_enable) begin
            alu_exec <= !take_fail();
            alu_res  <= alu_compute(alu_instr, alu_op1, alu_op2);
        end else begin
            alu_exec <= 1'b0;
        end
    end

    // Reference model: architectural semantics of the RV32I ALU subset.
    task automatic ref_exec(input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b,
                            output bit legal, output logic [31:0] op1,
                            output logic [31:0] op2, output logic [31:0] res);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] uimm;
        logic [4:0]  sh;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        imm  = {{20{ins[31]}}, ins[31:20]};
        uimm = {ins[31:12], 12'd0};
        sh   = ins[24:20];
        legal = 1'b0; op1 = 32'd0; op2 = 32'd0; res = 32'd0;
        if (opc == 7'h37) begin
            legal = 1'b1; op1 = uimm; res = uimm;
        end else if (opc == 7'h17) begin
            legal = 1'b1; op1 = uimm; op2 = pc; res = uimm + pc;
        end else if (opc == 7'h13) begin
            op1 = a; op2 = imm; legal = 1'b1;
            case (f3)
                3'd0: res = a + imm;
                3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: res = (a < imm) ? 32'd1 : 32'd0;
                3'd4: res = a ^ imm;
                3'd6: res = a | imm;
                3'd7: res = a & imm;
                3'd1: begin
                    op2 = {27'd0, sh}; res = a << sh; legal = (f7 == 7'h00);
                end
                default: begin
                    op2 = {27'd0, sh};
                    if (f7 == 7'h00) res = a >> sh;
                    else res = 32'($signed(a) >>> sh);
                    legal = (f7 == 7'h00 || f7 == 7'h20);
                end
            endcase
        end else if (opc == 7'h33) begin
            op1 = a; op2 = b;
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            case (f3)
                3'd0: res = (f7 == 7'h20) ? a - b : a + b;
                3'd1: res = a << b[4:0];
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: res = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end
        if (!legal) begin op1 = 32'd0; op2 = 32'd0; end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an ALU issue or a result.
    initial begin
        op_exp_t o;
        ev_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (alu_enable) begin
                    if (op_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL alu_enable_unexpected actual=1 required=0 cyc=%0d", cyc);
                    end else begin
                        o = op_q.pop_front();
                        check("alu_op1", alu_op1, o.op1);
                        check("alu_op2", alu_op2, o.op2);
                        check("alu_enable_cycle", cyc, o.cyc);
                    end
                end
                if (wb_en || illegal) begin
                    if (ev_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL event_unexpected wb_en=%0b illegal=%0b wb_addr=%0d cyc=%0d",
                                 wb_en, illegal, wb_addr, cyc);
                    end else begin
                        e = ev_q.pop_front();
                        check("ev_illegal", {31'd0, illegal}, {31'd0, e.ill});
                        check("ev_wb_en", {31'd0, wb_en}, {31'd0, !e.ill});
                        check("ev_cycle", cyc, e.cyc);
                        if (!e.ill) begin
                            check("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                            check("wb_data", wb_data, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        ok = in_ready;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout in_ready=0 required=1 cyc=%0d", cyc);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input bit fail);
        bit          legal, ok;
        logic [31:0] op1, op2, res;
        logic [4:0]  rd;
        int          acc;
        ref_exec(ins, pc, shadow[ins[19:15]], shadow[ins[24:20]], legal, op1, op2, res);
        rd = ins[11:7];
        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
        if (!legal) begin
            ev_q.push_back('{1'b1, 5'd0, 32'd0, acc});
        end else begin
            op_q.push_back('{op1, op2, acc});
            fail_q.push_back(fail);
            if (fail) ev_q.push_back('{1'b1, 5'd0, 32'd0, acc + 1});
            else if (rd != 5'd0) begin
                ev_q.push_back('{1'b0, rd, res, acc + 1});
                shadow[rd] = res;
            end
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    task automatic reset_mid_wait();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1;
        in_instr = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd5, 7'h33);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_q.push_back('{shadow[5], shadow[5], cyc});
        fail_q.push_back(1'b0);
        @(posedge clk); #1;
        check("busy_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1; #1;
        check("rst_wait_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_wait_busy", {31'd0, busy}, 32'd0);
        check("rst_wait_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_release_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins, rnd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  bad_opc [6];
        logic [2:0]  i_f3 [6];
        int          k;
        bad_opc = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73};
        i_f3    = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        for (int i = 0; i < 32; i++) begin rf[i] = 32'd0; shadow[i] = 32'd0; end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_alu_enable", {31'd0, alu_enable}, 32'd0);
        check("reset_wb_en", {31'd0, wb_en}, 32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);
        check("reset_alu_op1", alu_op1, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd5, 7'h13), 32'h0, 1'b0);
        reset_mid_wait();

        issue(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13), 32'h0, 1'b0);
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2, 7'h33), 32'h4, 1'b0);
        issue(enc_u(20'h12345, 5'd3, 7'h37), 32'h8, 1'b0);
        issue(enc_u(20'h00001, 5'd4, 7'h17), 32'h100, 1'b0);
        issue(enc_u(20'h80000, 5'd1, 7'h37), 32'h104, 1'b0);
        issue(enc_i({7'h20, 5'd4}, 5'd1, 3'd5, 5'd6, 7'h13), 32'h108, 1'b0);
        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13), 32'h10C, 1'b0);
        issue(enc_i(12'd0, 5'd2, 3'd2, 5'd7, 7'h03), 32'h110, 1'b0);
        issue(enc_i(12'd3, 5'd0, 3'd0, 5'd7, 7'h13), 32'h114, 1'b1);

        for (int n = 0; n < 60; n++) begin
            k   = $urandom_range(0, 9);
            rnd = $urandom();
            f3  = rnd[14:12];
            case (k)
                0, 1, 2: begin
                    f7 = ((f3 == 3'd0 || f3 == 3'd5) && rnd[30]) ? 7'h20 : 7'h00;
                    ins = enc_r(f7, rnd[24:20] & 5'd7, rnd[19:15] & 5'd7, f3, rnd[11:7] & 5'd7, 7'h33);
                end
                3, 4: ins = enc_i(rnd[31:20], rnd[19:15] & 5'd7, i_f3[$urandom_range(0, 5)],
                                  rnd[11:7] & 5'd7, 7'h13);
                5: begin
                    f3 = rnd[0] ? 3'd1 : 3'd5;
                    f7 = (f3 == 3'd5 && rnd[30]) ? 7'h20 : 7'h00;
                    ins = enc_i({f7, rnd[24:20]}, rnd[19:15] & 5'd7, f3, rnd[11:7] & 5'd7, 7'h13);
                end
                6: ins = enc_u(rnd[31:12], rnd[11:7] & 5'd7, 7'h37);
                7: ins = enc_u(rnd[31:12], rnd[11:7] & 5'd7, 7'h17);
                8: ins = {rnd[31:7], bad_opc[$urandom_range(0, 5)]};
                default: ins = rnd[0] ? enc_r(7'h01, rnd[24:20], rnd[19:15], f3, rnd[11:7], 7'h33)
                                      : enc_i({7'h20, rnd[24:20]}, rnd[19:15], 3'd1, rnd[11:7], 7'h13);
            endcase
            issue(ins, $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 9) == 0));
        end

        repeat (10) @(negedge clk);
        check("pending_events", ev_q.size(), 32'd0);
        check("pending_alu_ops", op_q.size(), 32'd0);
        for (int i = 0; i < 32; i++) check($sformatf("rf_x%0d", i), rf[i], shadow[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
